// File: rtl/riscv_lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RISC-V
// width codes and response error codes.
package riscv_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_FUNCT3   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: byte enables, store-data replication and load
// extract/extend. Purely combinational.
module lsu_align
    import riscv_lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        off_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [3:0]        be_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] ld_data_o
);

    logic [DATA_W-1:0] shifted;

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_o    = 4'b0011 << {off_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Move the addressed byte/halfword down to lane 0 before extending.
    assign shifted = rdata_i >> {off_i, 3'b000};

    always_comb begin
        ld_data_o = shifted;
        case (funct3_i)
            F3_B:    ld_data_o = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
            F3_H:    ld_data_o = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
            F3_BU:   ld_data_o = {{(DATA_W-8){1'b0}}, shifted[7:0]};
            F3_HU:   ld_data_o = {{(DATA_W-16){1'b0}}, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: takes one core request at a time, runs a handshaked SRAM
// access with a timeout, and returns a formatted one-cycle response.
module lsu_mem_ctrl
    import riscv_lsu_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [1:0]        resp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    lsu_state_t        state_q;
    logic [7:0]        timer_q;
    logic              wr_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        err_q;

    logic              illegal, misal, in_access;
    logic [3:0]        be;
    logic [DATA_W-1:0] st_data, ld_data;

    // Loads-only codes (BU/HU) are illegal as stores.
    assign illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                     (req_funct3[2] && req_write);
    assign misal   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .funct3_i  (f3_q),
        .off_i     (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .rdata_i   (mem_rdata),
        .be_o      (be),
        .wdata_o   (st_data),
        .ld_data_o (ld_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            wr_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= ERR_OK;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    wr_q    <= req_write;
                    f3_q    <= req_funct3;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    timer_q <= '0;
                    rdata_q <= '0;
                    if (illegal) begin
                        err_q   <= ERR_FUNCT3;
                        state_q <= DONE;
                    end else if (misal) begin
                        err_q   <= ERR_MISALIGN;
                        state_q <= DONE;
                    end else begin
                        err_q   <= ERR_OK;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        rdata_q <= wr_q ? '0 : ld_data;
                        err_q   <= ERR_OK;
                        state_q <= DONE;
                    end else if (timer_q == 8'(TIMEOUT - 1)) begin
                        err_q   <= ERR_TIMEOUT;
                        state_q <= DONE;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_access  = (state_q == ACCESS);
    assign mem_en     = in_access;
    assign mem_we     = in_access & wr_q;
    assign mem_be     = in_access ? be : 4'b0000;
    assign mem_addr   = in_access ? addr_q[ADDR_W-1:2] : '0;
    assign mem_wdata  = in_access ? st_data : '0;

    assign resp_valid = (state_q == DONE);
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign resp_err   = resp_valid ? err_q : ERR_OK;

    // Gated by reset so the stall drops immediately even with req_valid high.
    assign busy = reset & (((state_q == IDLE) & req_valid) | in_access);

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with hand-computed expectations.
module tb_lsu_mem_ctrl;

    localparam int ADDR_W  = 9;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_write = 1'b0;
    logic [2:0]        req_funct3 = '0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              busy, resp_valid, mem_en, mem_we;
    logic [DATA_W-1:0] resp_rdata, mem_wdata;
    logic [1:0]        resp_err;
    logic [3:0]        mem_be;
    logic [ADDR_W-3:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ready = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    lsu_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .busy       (busy),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive(input logic w, input logic [2:0] f3, input logic [8:0] a,
                         input logic [31:0] wd);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
    endtask

    // Accepted access with mem_ready on the nacc-th ACCESS cycle.
    task automatic run_mem(input string tag, input logic w, input logic [2:0] f3,
                           input logic [8:0] a, input logic [31:0] wd, input logic [31:0] rd,
                           input int nacc, input logic [3:0] e_be, input logic [6:0] e_addr,
                           input logic [31:0] e_wd, input logic [31:0] e_rdata);
        int busy_n;
        nxt();
        drive(w, f3, a, wd);
        mem_rdata = rd;
        mem_ready = 1'b0;
        mid();
        chk({tag, "_accept_busy"}, busy, 1);
        chk({tag, "_accept_mem_en"}, mem_en, 0);
        chk({tag, "_accept_no_resp"}, resp_valid, 0);
        busy_n = 1;
        for (int i = 1; i <= nacc; i++) begin
            nxt();
            mem_ready = (i == nacc);
            mid();
            chk({tag, "_mem_en"}, mem_en, 1);
            chk({tag, "_mem_we"}, mem_we, w);
            chk({tag, "_mem_be"}, mem_be, e_be);
            chk({tag, "_mem_addr"}, mem_addr, e_addr);
            if (w) chk({tag, "_mem_wdata"}, mem_wdata, e_wd);
            if (busy) busy_n++;
        end
        nxt();
        mem_ready = 1'b0;
        req_valid = 1'b0;
        mid();
        chk({tag, "_resp_valid"}, resp_valid, 1);
        chk({tag, "_resp_err"}, resp_err, 2'b00);
        chk({tag, "_resp_rdata"}, resp_rdata, e_rdata);
        chk({tag, "_done_busy"}, busy, 0);
        chk({tag, "_done_mem_en"}, mem_en, 0);
        chk({tag, "_busy_cycles"}, busy_n, nacc + 1);
    endtask

    task automatic run_err(input string tag, input logic w, input logic [2:0] f3,
                           input logic [8:0] a, input logic [1:0] e_err);
        nxt();
        drive(w, f3, a, 32'h1234_5678);
        mid();
        chk({tag, "_accept_busy"}, busy, 1);
        chk({tag, "_accept_mem_en"}, mem_en, 0);
        nxt();
        req_valid = 1'b0;
        mid();
        chk({tag, "_resp_valid"}, resp_valid, 1);
        chk({tag, "_resp_err"}, resp_err, e_err);
        chk({tag, "_resp_rdata"}, resp_rdata, 0);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int   cnt;
        logic got;

        // Reset held with a pending request: everything must be quiet.
        req_valid = 1'b1;
        mid();
        chk("rst_busy", busy, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        nxt();
        reset     = 1'b1;
        req_valid = 1'b0;

        run_mem("sw",   1, 3'b010, 9'h008, 32'hDEADBEEF, 32'h0, 1, 4'b1111, 7'h02, 32'hDEADBEEF, 32'h0);
        run_mem("lb",   0, 3'b000, 9'h007, 32'h0, 32'h80123456, 3, 4'b1000, 7'h01, 32'h0, 32'hFFFFFF80);
        run_mem("lbu",  0, 3'b100, 9'h007, 32'h0, 32'h80123456, 3, 4'b1000, 7'h01, 32'h0, 32'h00000080);
        run_mem("sh",   1, 3'b001, 9'h00A, 32'h0000ABCD, 32'h0, 1, 4'b1100, 7'h02, 32'hABCDABCD, 32'h0);
        run_mem("lhu",  0, 3'b101, 9'h002, 32'h0, 32'h9ABC0000, 2, 4'b1100, 7'h00, 32'h0, 32'h00009ABC);
        run_mem("lh",   0, 3'b001, 9'h002, 32'h0, 32'h9ABC0000, 1, 4'b1100, 7'h00, 32'h0, 32'hFFFF9ABC);
        run_mem("sb",   1, 3'b000, 9'h1FD, 32'h0000005A, 32'h0, 1, 4'b0010, 7'h7F, 32'h5A5A5A5A, 32'h0);
        run_mem("lbu1", 0, 3'b100, 9'h001, 32'h0, 32'h0000FE00, 1, 4'b0010, 7'h00, 32'h0, 32'h000000FE);
        run_mem("lw",   0, 3'b010, 9'h1FC, 32'h0, 32'h12345678, 2, 4'b1111, 7'h7F, 32'h0, 32'h12345678);

        run_err("lw_mis",  0, 3'b010, 9'h005, 2'b01);
        run_err("lh_mis",  0, 3'b001, 9'h003, 2'b01);
        run_err("f3_011",  0, 3'b011, 9'h000, 2'b10);
        run_err("f3_111",  0, 3'b111, 9'h000, 2'b10);
        run_err("sbu",     1, 3'b100, 9'h000, 2'b10);
        run_err("shu",     1, 3'b101, 9'h004, 2'b10);
        run_err("f3_prio", 0, 3'b110, 9'h001, 2'b10);

        // Timeout: mem_ready never comes.
        nxt();
        drive(0, 3'b010, 9'h010, 32'h0);
        mem_ready = 1'b0;
        mid();
        chk("to_accept_busy", busy, 1);
        cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            nxt();
            req_valid = 1'b0;
            mid();
            if (resp_valid) got = 1'b1;
            else if (mem_en) cnt++;
        end
        chk("to_resp_seen", got, 1);
        chk("to_mem_en_cycles", cnt, TIMEOUT);
        chk("to_resp_err", resp_err, 2'b11);
        chk("to_resp_rdata", resp_rdata, 0);

        // Ready arriving on the last allowed cycle beats the timeout.
        run_mem("to_edge", 0, 3'b010, 9'h010, 32'h0, 32'hCAFEF00D, TIMEOUT, 4'b1111, 7'h04, 32'h0, 32'hCAFEF00D);

        // Reset asserted mid-ACCESS.
        nxt();
        drive(0, 3'b010, 9'h020, 32'h0);
        nxt();
        mid();
        chk("rma_mem_en_before", mem_en, 1);
        #2 reset = 1'b0;
        #1;
        chk("rma_mem_en", mem_en, 0);
        chk("rma_busy", busy, 0);
        chk("rma_resp_valid", resp_valid, 0);
        nxt();
        reset     = 1'b1;
        req_valid = 1'b0;
        mid();
        chk("rma_post_resp", resp_valid, 0);
        nxt();
        mid();
        chk("rma_post_resp2", resp_valid, 0);
        chk("rma_post_mem_en", mem_en, 0);
        run_mem("rma_lw", 0, 3'b010, 9'h024, 32'h0, 32'h0BADF00D, 1, 4'b1111, 7'h09, 32'h0, 32'h0BADF00D);

        // req_valid held through DONE is only taken again once back in IDLE.
        nxt();
        drive(0, 3'b011, 9'h000, 32'h0);
        mid();
        chk("hold_accept_busy", busy, 1);
        nxt();
        mid();
        chk("hold_done_resp", resp_valid, 1);
        chk("hold_done_busy", busy, 0);
        nxt();
        mid();
        chk("hold_idle_resp", resp_valid, 0);
        chk("hold_idle_busy", busy, 1);
        nxt();
        req_valid = 1'b0;
        mid();
        chk("hold_done2_resp", resp_valid, 1);
        chk("hold_done2_err", resp_err, 2'b10);

        nxt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit between the core's memory request outputs and a handshaked data memory (SRAM port with a ready signal).
- Accepts one load/store per request and stalls the core while the access is pending.
- Generates byte enables and replicated store data, then aligns and sign- or zero-extends load data.
- Detects misaligned accesses, illegal funct3 codes and memory timeouts.

Parameters:
- ADDR_W, 9, byte address width; word address is ADDR_W-2 bits.
- DATA_W, 32, data width; only 32 is supported.
- TIMEOUT, 15, maximum ACCESS cycles without mem_ready before an error (1..255).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  core load/store request; held stable while busy=1
- req_write  in  1  1=store, 0=load
- req_funct3  in  3  RISC-V width code (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data (low bits significant)
- busy  out  1  stall to core
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_W  formatted load data; 0 for stores and errors
- resp_err  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout; valid with resp_valid
- mem_en  out  1  memory request
- mem_we  out  1  memory write
- mem_be  out  4  byte enables
- mem_addr  out  ADDR_W-2  word address
- mem_wdata  out  DATA_W  lane-replicated store data
- mem_rdata  in  DATA_W  read word, valid when mem_ready=1
- mem_ready  in  1  memory completion, one cycle

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, timer=0, latched request=0. All outputs drop to 0 immediately, including mem_en mid-ACCESS. A pending access is abandoned with no resp_valid.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Requests are sampled only in IDLE.
  - On req_valid: latch write, funct3, addr, wdata and classify the request.
  - Illegal funct3 (011, 110, 111, or 100/101 with req_write=1): go to DONE with err=10.
  - Misaligned (H with addr[0]=1, W with addr[1:0]≠0): go to DONE with err=01.
  - Otherwise go to ACCESS with timer=0.
  - Error checks take priority in that order. No memory access is made on any error.
- ACCESS:
  - mem_en=1; mem_we, mem_be, mem_addr and mem_wdata are driven from latched registers and held stable.
  - mem_ready=1: capture mem_rdata and go to DONE with err=00.
  - Otherwise timer++. When timer==TIMEOUT-1 and mem_ready=0, go to DONE with err=11.
  - mem_ready wins if it coincides with timeout.
- DONE: resp_valid=1 for exactly one cycle, then back to IDLE. req_valid is ignored in DONE.
- busy = (state==IDLE & req_valid) | (state==ACCESS). busy is 0 in DONE so the core advances while the response is presented.
- Byte enables:
  - B: 0001<<addr[1:0]
  - H: 0011<<{addr[1],1'b0}
  - W: 1111
  - Loads drive the same enables.
- Store data: B replicates wdata[7:0] ×4; H replicates wdata[15:0] ×2; W passes through.
- Load extract: shift mem_rdata right by 8·addr[1:0], take 8/16/32 bits, then sign-extend (B/H) or zero-extend (BU/HU).
- Latency: minimum 2 cycles from accepting in IDLE to resp_valid (ready on the first ACCESS cycle). An error request responds in 1 cycle (IDLE→DONE).
- mem_addr = req_addr[ADDR_W-1:2]; the top word wraps naturally.

Decomposition:
- Package riscv_lsu_pkg holds:
  - lsu_state_t enum (IDLE, ACCESS, DONE)
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - error codes (ERR_OK, ERR_MISALIGN, ERR_FUNCT3, ERR_TIMEOUT)
- One combinational sub-module, lsu_align, owns byte-enable generation, store replication and load extract/extend. The FSM, timer and latches stay in lsu_mem_ctrl.

Test Plan:
- SW addr=0x008, wdata=0xDEADBEEF, ready on the 1st ACCESS cycle -> mem_addr=0x02, be=1111, mem_wdata=0xDEADBEEF, mem_we=1; resp_valid 2 cycles after accept, err=00, rdata=0.
- LB addr=0x007, mem_rdata=0x80123456, ready after 3 cycles -> be=1000, resp_rdata=0xFFFFFF80. The same access as LBU -> 0x00000080. busy=1 for 4 cycles.
- SH addr=0x00A, wdata=0x0000ABCD -> be=1100, mem_wdata=0xABCDABCD. LHU addr=0x002 with rdata=0x9ABC0000 -> 0x00009ABC.
- LW addr=0x005 -> no mem_en, resp_valid on the next cycle with err=01. funct3=011 -> err=10. SBU (funct3=100, write=1) -> err=10.
- mem_ready held 0, TIMEOUT=15 -> mem_en high exactly 15 cycles, then resp_valid with err=11 and rdata=0. mem_ready coinciding with the 15th cycle -> err=00.
- Assert reset=0 mid-ACCESS -> mem_en, busy and resp_valid are 0 in the same cycle. After release the next request behaves normally. req_valid held during DONE is not re-accepted until IDLE.
